// File: rtl/bmem_types.sv
// Shared types for the 64-bit burst memory interface.
//  BMEM_BEATS       beats per 32-byte line
//  BMEM_BEAT_BITS   data width of one beat
//  BMEM_LINE_BYTES  bytes per line (sets the index LSB)
//  bmem_rd_req_t    queued read request: echoed address plus accept timestamp
//  bmem_rsp_st_e    response sequencer states
package bmem_types;

  localparam int unsigned BMEM_BEATS      = 4;
  localparam int unsigned BMEM_BEAT_BITS  = 64;
  localparam int unsigned BMEM_LINE_BYTES = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] ts;
  } bmem_rd_req_t;

  typedef enum logic {StIdle, StBurst} bmem_rsp_st_e;

endpackage

// File: rtl/bmem_req_fifo.sv
// Synchronous FIFO of pending read requests.
//  clk_i/rst_i   clock, asynchronous active-high reset (empties the FIFO)
//  push_i/data_i enqueue one request (ignored when full)
//  pop_i         drop the head entry (ignored when empty)
//  head_o        oldest entry, valid while empty_o is low
//  full_o/empty_o/count_o occupancy status
module bmem_req_fifo
  import bmem_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  bmem_rd_req_t               data_i,
  input  logic                       pop_i,
  output bmem_rd_req_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  bmem_rd_req_t    mem_q [DEPTH];
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bmem_responder.sv
// Responder end of the 64-bit burst memory interface: stores 32-byte lines and returns
// read data as 4 in-order beats a fixed number of cycles after the read is accepted.
//  clk_i, rst_i        clock, asynchronous active-high reset (line array is not cleared)
//  bmem_addr_i         line address; index = addr[LINE_IDX_BITS+4:5], upper bits alias
//  bmem_read_i         one-cycle read request
//  bmem_write_i        write beat valid, 4 consecutive beats per line
//  bmem_wdata_i        write beat data
//  bmem_ready_o        request/beat accepted this cycle
//  bmem_raddr_o        echo of the accepted address for the line being returned
//  bmem_rdata_o        read beat data
//  bmem_rvalid_o       read beat valid
module bmem_responder
  import bmem_types::*;
#(
  parameter int unsigned LINE_IDX_BITS = 8,
  parameter int unsigned LATENCY       = 6,
  parameter int unsigned QDEPTH        = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               bmem_addr_i,
  input  logic                      bmem_read_i,
  input  logic                      bmem_write_i,
  input  logic [BMEM_BEAT_BITS-1:0] bmem_wdata_i,
  output logic                      bmem_ready_o,
  output logic [31:0]               bmem_raddr_o,
  output logic [BMEM_BEAT_BITS-1:0] bmem_rdata_o,
  output logic                      bmem_rvalid_o
);

  localparam int unsigned LineLsb  = $clog2(BMEM_LINE_BYTES);
  localparam int unsigned NumLines = 1 << LINE_IDX_BITS;
  localparam int unsigned CntW     = $clog2(QDEPTH) + 1;

  logic [BMEM_BEAT_BITS-1:0] mem_q [NumLines][BMEM_BEATS];

  logic                      rdy_en_q;
  logic [1:0]                wr_cnt_q, wr_cnt_d;
  logic [15:0]               ts_q;
  bmem_rsp_st_e              state_q, state_d;
  logic [1:0]                beat_q, beat_d;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               raddr_q, raddr_d;
  logic [BMEM_BEAT_BITS-1:0] rdata_q, rdata_d;

  logic                      wr_busy, wr_en, rd_acc, due, load;
  logic [LINE_IDX_BITS-1:0]  wr_idx, rd_idx;
  logic [1:0]                rd_beat;
  logic [15:0]               age;
  bmem_rd_req_t              push_req, head;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]           unused_fifo_cnt;

  // rdy_en_q keeps ready low while in reset and releases it on the first edge after.
  assign wr_busy      = (wr_cnt_q != 2'd0);
  assign bmem_ready_o = rdy_en_q & (~fifo_full | wr_busy);
  assign wr_en        = bmem_write_i & bmem_ready_o;
  assign rd_acc       = bmem_read_i & bmem_ready_o & ~wr_busy & ~bmem_write_i;
  assign wr_cnt_d     = wr_en ? wr_cnt_q + 2'd1 : wr_cnt_q;
  assign wr_idx       = bmem_addr_i[LINE_IDX_BITS+LineLsb-1:LineLsb];
  assign push_req     = '{addr: bmem_addr_i, ts: ts_q};

  bmem_req_fifo #(
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rd_acc),
    .data_i  (push_req),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_cnt)
  );

  // Decisions made this cycle appear on the registered outputs next cycle, so the
  // age is measured against ts_q + 1 to land beat 0 exactly LATENCY after accept.
  assign rd_idx = head.addr[LINE_IDX_BITS+LineLsb-1:LineLsb];
  assign age    = ts_q + 16'd1 - head.ts;
  assign due    = ~fifo_empty & (age >= 16'(LATENCY));

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    rd_beat  = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (due) begin
          load    = 1'b1;
          beat_d  = 2'd1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        load    = 1'b1;
        rd_beat = beat_q;
        beat_d  = beat_q + 2'd1;
        // Popping with beat 3 lets the next head start beat 0 right behind it.
        if (beat_q == 2'd3) begin
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end
      end
    endcase
    if (load) begin
      rvalid_d = 1'b1;
      raddr_d  = head.addr;
      // Forward a same-cycle write so the beat reflects the newest data.
      if (wr_en && (wr_idx == rd_idx) && (wr_cnt_q == rd_beat)) begin
        rdata_d = bmem_wdata_i;
      end else begin
        rdata_d = mem_q[rd_idx][rd_beat];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_en_q <= 1'b0;
      wr_cnt_q <= 2'd0;
      ts_q     <= 16'd0;
      state_q  <= StIdle;
      beat_q   <= 2'd0;
      rvalid_q <= 1'b0;
      raddr_q  <= 32'd0;
      rdata_q  <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      wr_cnt_q <= wr_cnt_d;
      ts_q     <= ts_q + 16'd1;
      state_q  <= state_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx][wr_cnt_q] <= bmem_wdata_i;
  end

  assign bmem_rvalid_o = rvalid_q;
  assign bmem_raddr_o  = raddr_q;
  assign bmem_rdata_o  = rdata_q;

  // A read alongside a write beat, or inside a write burst, is dropped.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(bmem_read_i && (bmem_write_i || wr_busy)));

endmodule

// File: tb/tb_bmem_responder.sv
module tb_bmem_responder;

  localparam int L = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  always #5 clk = ~clk;

  bmem_responder #(
    .LINE_IDX_BITS (8),
    .LATENCY       (L),
    .QDEPTH        (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bmem_addr_i   (bmem_addr),
    .bmem_read_i   (bmem_read),
    .bmem_write_i  (bmem_write),
    .bmem_wdata_i  (bmem_wdata),
    .bmem_ready_o  (bmem_ready),
    .bmem_raddr_o  (bmem_raddr),
    .bmem_rdata_o  (bmem_rdata),
    .bmem_rvalid_o (bmem_rvalid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference: line store plus a queue of expected line returns with start cycles.
  logic [63:0] model [256][4];
  typedef struct {
    logic [31:0] addr;
    int          start;
  } exp_t;
  exp_t exp_q[$];
  int   last_start = -100;
  bit   mon_en = 1'b0;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[12:5]);
  endfunction

  always @(negedge clk) begin : monitor
    int          b;
    logic [63:0] ed;
    if (mon_en) begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].start) begin
        b  = cyc - exp_q[0].start;
        ed = model[idx_of(exp_q[0].addr)][b];
        checks++;
        if (bmem_rvalid !== 1'b1 || bmem_raddr !== exp_q[0].addr || bmem_rdata !== ed) begin
          errors++;
          if (errors < 50)
            $display("FAIL beat cyc=%0d beat=%0d got v=%b a=%h d=%h want v=1 a=%h d=%h",
                     cyc, b, bmem_rvalid, bmem_raddr, bmem_rdata, exp_q[0].addr, ed);
        end
        if (b == 3) exp_q.delete(0);
      end else begin
        checks++;
        if (bmem_rvalid !== 1'b0) begin
          errors++;
          if (errors < 50) $display("FAIL idle_rvalid cyc=%0d got %b want 0", cyc, bmem_rvalid);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [63:0] d [4]);
    int n;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bmem_write = 1'b1;
      bmem_addr  = a;
      bmem_wdata = d[k];
      n = 0;
      while (bmem_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL wr_ready_timeout addr=%h got ready=%b want 1", a, bmem_ready);
      end
      @(posedge clk);
      model[idx_of(a)][k] = d[k];
    end
    #1 bmem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output int waited, output int tacc);
    int st;
    @(negedge clk);
    bmem_read = 1'b1;
    bmem_addr = a;
    waited = 0;
    while (bmem_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL rd_ready_timeout addr=%h got ready=%b want 1", a, bmem_ready);
    end
    tacc = cyc;
    st = cyc + L;
    if (st < last_start + 4) st = last_start + 4;
    last_start = st;
    exp_q.push_back('{addr: a, start: st});
    @(posedge clk);
    #1 bmem_read = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_latency(input int tacc, input string name);
    int n = 0;
    @(negedge clk);
    while (bmem_rvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - tacc != L) begin
      errors++;
      $display("FAIL %s got latency=%0d want %0d", name, cyc - tacc, L);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int line);
    return ($urandom() & 32'hFFFF_E000) | (32'(line) << 5) | ($urandom() & 32'h1F);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bmem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bmem_ready); end
    if (bmem_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", bmem_rvalid); end
    if (bmem_raddr !== 32'd0) begin errors++; $display("FAIL rst_raddr got %h want 0", bmem_raddr); end
    if (bmem_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", bmem_rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", bmem_ready); end
    mon_en = 1'b1;
  endtask

  task automatic init_lines();
    logic [63:0] d [4];
    for (int l = 0; l < 32; l++) begin
      for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
      wr(32'(l) << 5, d);
    end
  endtask

  task automatic test_single();
    logic [63:0] d [4];
    int w, t;
    d = '{64'd1, 64'd2, 64'd3, 64'd4};
    wr(32'h40, d);
    rd(32'h40, w, t);
    check_latency(t, "single_latency");
    drain();
  endtask

  task automatic test_back_to_back();
    int w, t;
    rd(32'h00, w, t);
    rd(32'h20, w, t);
    rd(32'h40, w, t);
    rd(32'h60, w, t);
    rd(32'h80, w, t);
    checks++;
    if (w < 5 || w > 6) begin
      errors++;
      $display("FAIL full_wait got %0d cycles want 5..6", w);
    end
    drain();
  endtask

  task automatic test_write_read();
    logic [63:0] d [4];
    logic [31:0] a;
    int w, t, l;
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(0, 31);
      a = rand_addr(l);
      for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
      wr(a, d);
      rd(a, w, t);
      rd(rand_addr((l + 1 + $urandom_range(0, 29)) % 32), w, t);
      drain();
    end
  endtask

  task automatic test_alias();
    logic [63:0] d [4];
    int w, t;
    for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
    wr(32'h0000_0020, d);
    rd(32'h0000_2020, w, t);
    drain();
    checks++;
    if (model[1][2] !== d[2]) begin
      errors++;
      $display("FAIL alias_model got %h want %h", model[1][2], d[2]);
    end
  endtask

  task automatic test_random();
    logic [63:0] d [4];
    int w, t;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom()};
          wr(rand_addr($urandom_range(0, 31)), d);
        end
        1, 2: rd(rand_addr($urandom_range(0, 31)), w, t);
        default: repeat ($urandom_range(1, 8)) @(negedge clk);
      endcase
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int w, t, n;
    rd(32'h40, w, t);
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() > 0 && cyc == exp_q[0].start + 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks += 2;
    if (bmem_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b want 0", bmem_rvalid); end
    if (bmem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", bmem_ready); end
    exp_q.delete();
    last_start = -100;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bmem_ready !== 1'b1) begin errors++; $display("FAIL midrst_rel_ready got %b want 1", bmem_ready); end
    mon_en = 1'b1;
    rd(32'h40, w, t);
    drain();
  endtask

  task automatic test_ts_wrap();
    int w, t;
    repeat (70000) @(negedge clk);
    rd(32'h60, w, t);
    check_latency(t, "wrap_latency");
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    init_lines();
    test_single();
    test_back_to_back();
    test_write_read();
    test_alias();
    test_random();
    test_reset_mid_burst();
    test_ts_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
